// File: rtl/median3x3_stream.sv
// median3x3_stream: raster-stream 3x3 median filter, two line buffers feeding a 4-stage median-of-9 pipeline.
// Define MEDIAN3X3_MINMAX_EN to also emit the window min and max (out_min/out_max).
module median3x3_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pixel,
`ifdef MEDIAN3X3_MINMAX_EN
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
`endif
    output logic              out_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    typedef logic [8:0][DATA_W-1:0] win_t;

    function automatic win_t cx(input win_t v, input int i, input int j);
        cx = v;
        if (v[i[3:0]] > v[j[3:0]]) begin
            cx[i[3:0]] = v[j[3:0]];
            cx[j[3:0]] = v[i[3:0]];
        end
    endfunction

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    win_t              w, s0, s1, s2, n1, n2r, n2, n3;
    logic              win_v, win_l, v0, l0, v1, l1, v2, l2;
    logic              en, acc, eol;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign acc      = in_valid && en;
    assign eol      = col == COL_MAX;

    // 19 compare-exchanges split 6/6/7; after n2r every row of three is sorted
    always_comb begin
        n1 = cx(cx(cx(s0, 1, 2), 4, 5), 7, 8);
        n1 = cx(cx(cx(n1, 0, 1), 3, 4), 6, 7);
        n2r = cx(cx(cx(s1, 1, 2), 4, 5), 7, 8);
        n2 = cx(cx(cx(n2r, 0, 3), 5, 8), 4, 7);
        n3 = cx(cx(cx(s2, 3, 6), 1, 4), 2, 5);
        n3 = cx(cx(cx(cx(n3, 4, 7), 4, 2), 6, 4), 4, 2);
    end

    // w[2:0] = row r-2, w[5:3] = row r-1, w[8:6] = row r, oldest column lowest
    always_ff @(posedge clk) begin
        if (acc) begin
            lb0[col] <= in_pixel;
            lb1[col] <= lb0[col];
            w <= {in_pixel, w[8:7], lb0[col], w[5:4], lb1[col], w[2:1]};
        end
        if (en) begin
            s0 <= w;
            s1 <= n1;
            s2 <= n2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            {win_v, win_l, v0, l0, v1, l1, v2, l2} <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_pixel <= '0;
        end else if (en) begin
            if (acc) begin
                col <= eol ? '0 : col + 1'b1;
                row <= eol ? (row == ROW_MAX ? '0 : row + 1'b1) : row;
            end
            win_v <= acc && row >= RW'(2) && col >= CW'(2);
            win_l <= acc && eol && row == ROW_MAX;
            {v0, l0} <= {win_v, win_l};
            {v1, l1} <= {v0, l0};
            {v2, l2} <= {v1, l1};
            out_valid <= v2;
            out_last <= l2;
            out_pixel <= n3[4];
        end
    end

`ifdef MEDIAN3X3_MINMAX_EN
    logic [DATA_W-1:0] mn_a, mx_a, mn2, mx2;
    assign mn_a = n2r[0] < n2r[3] ? n2r[0] : n2r[3];
    assign mx_a = n2r[2] > n2r[5] ? n2r[2] : n2r[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            mn2 <= '0;
            mx2 <= '0;
            out_min <= '0;
            out_max <= '0;
        end else if (en) begin
            mn2 <= mn_a < n2r[6] ? mn_a : n2r[6];
            mx2 <= mx_a > n2r[8] ? mx_a : n2r[8];
            out_min <= mn2;
            out_max <= mx2;
        end
    end
`endif
endmodule

// File: tb/tb_median3x3_stream.sv
// tb_median3x3_stream: directed 5x4-frame vectors, expected outputs queued at issue and popped by a monitor.
module tb_median3x3_stream;
    typedef struct {
        logic [7:0] pix;
        logic [7:0] mn;
        logic [7:0] mx;
        logic       last;
        logic       mm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_pixel = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_pixel;
    logic       out_last;
`ifdef MEDIAN3X3_MINMAX_EN
    logic [7:0] out_min, out_max;
`endif

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         meds[6] = '{6, 7, 8, 11, 12, 13};
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         acc12 = 0;
    bit         arm = 0;
    bit         lat_armed = 0;
    bit         bp = 0;
    int         bp_k = 0;
    logic [3:0] bp_pat = 4'b1001;
    bit         hold = 0;
    logic [7:0] h_pix;
    logic       h_last;

    median3x3_stream #(.DATA_W(8), .IMG_W(5), .IMG_H(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pixel(in_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pixel(out_pixel),
`ifdef MEDIAN3X3_MINMAX_EN
        .out_min(out_min),
        .out_max(out_max),
`endif
        .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // downstream ready follows 1,0,0,1 while backpressure is on
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp ? bp_pat[bp_k % 4] : 1'b1;
        if (bp) bp_k++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) hold = 0;
        else begin
            if (hold) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_pixel", int'(out_pixel), int'(h_pix));
                chk("stall_last", int'(out_last), int'(h_last));
            end
            if (out_valid && lat_armed) begin
                chk("latency", cyc - acc12, 4);
                lat_armed = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pixel %0d, expected no output", out_pixel);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("median", int'(out_pixel), int'(mon_e.pix));
                    chk("out_last", int'(out_last), int'(mon_e.last));
`ifdef MEDIAN3X3_MINMAX_EN
                    if (mon_e.mm) begin
                        chk("out_min", int'(out_min), int'(mon_e.mn));
                        chk("out_max", int'(out_max), int'(mon_e.mx));
                    end
`endif
                end
            end
            hold = out_valid && !out_ready;
            h_pix = out_pixel;
            h_last = out_last;
        end
    end

    task automatic push_ramp(input int off);
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            e.pix = 8'(meds[i] + off);
            e.mn = 8'(meds[i] + off - 6);
            e.mx = 8'(meds[i] + off + 6);
            e.last = (i == 5);
            e.mm = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] px, input int idx);
        bit ok = 0;
        in_valid = 1'b1;
        in_pixel = px;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accept", int'(ok), 1);
        if (ok && arm && idx == 12) begin
            acc12 = cyc;
            lat_armed = 1;
            arm = 0;
        end
    endtask

    task automatic send_frame(input int off, input bit impulse, input bit gaps);
        for (int i = 0; i < 20; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(impulse ? (i == 6 ? 8'd255 : 8'd10) : 8'(i + off), i);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_remaining", exp_q.size(), 0);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_last", int'(out_last), 0);
        chk("reset_out_pixel", int'(out_pixel), 0);
`ifdef MEDIAN3X3_MINMAX_EN
        chk("reset_out_min", int'(out_min), 0);
        chk("reset_out_max", int'(out_max), 0);
`endif
        rst = 1'b0;

        push_ramp(0);
        arm = 1;
        send_frame(0, 0, 0);
        drain();

        for (int i = 0; i < 6; i++) begin
            e.pix = 8'd10;
            e.mn = 8'd0;
            e.mx = 8'd0;
            e.last = (i == 5);
            e.mm = 1'b0;
            exp_q.push_back(e);
        end
        send_frame(0, 1, 0);
        drain();

        push_ramp(0);
        push_ramp(100);
        send_frame(0, 0, 0);
        send_frame(100, 0, 0);
        drain();

        bp = 1;
        push_ramp(0);
        send_frame(0, 0, 1);
        drain();
        bp = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 8; i++) send(8'(i), i);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_out_valid", int'(out_valid), 0);
        push_ramp(0);
        arm = 1;
        send_frame(0, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
